// File: rtl/typing_stats.sv
// rtl/typing_stats.sv - typing round keystroke/second counters with serial WPM and accuracy divide
// Optional: define TYPING_STATS_ERR_OUT_EN to add the err_cnt output.
module typing_stats #(
    parameter int TICK_CYCLES = 100000000,
    parameter int CNT_W       = 12,
    parameter int WPM_MAX     = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             key_valid,
    input  logic             key_correct,
    output logic             busy,
    output logic [9:0]       elapsed_sec,
    output logic [9:0]       wpm,
    output logic [9:0]       acc,
    output logic             finish
`ifdef TYPING_STATS_ERR_OUT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int DW     = 19;
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DW-1:0]     WPM_MAX_Q = DW'(WPM_MAX);
    localparam logic [4:0]        DIV_LAST  = 5'd18;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DIV_W, S_DIV_A, S_DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  total_cnt, correct_cnt, total_nxt, correct_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic [9:0]        elapsed_nxt;
    logic              tick_wrap, start_run;

    logic [DW-1:0]     div_q, div_d, div_r, q_nxt, r_nxt;
    logic [DW:0]       trial;
    logic              ge;
    logic [4:0]        div_cnt;
    logic [9:0]        wpm_tmp, acc_tmp;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (stop) state_nxt = S_DIV_W;
            end
            S_DIV_W: begin
                busy = 1'b1;
                if (div_cnt == DIV_LAST) state_nxt = S_DIV_A;
            end
            S_DIV_A: begin
                busy = 1'b1;
                if (div_cnt == DIV_LAST) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // stop outranks start, so a restart only happens when stop is absent
    assign start_run = start && ((state == S_IDLE) || (state == S_RUN && !stop));

    // Next-cycle counter values; the stop edge still counts, so the WPM operands use these
    assign tick_wrap   = (tick_cnt == TICK_LAST);
    assign tick_nxt    = tick_wrap ? '0 : tick_cnt + 1'b1;
    assign elapsed_nxt = (tick_wrap && elapsed_sec != 10'd1023) ? elapsed_sec + 10'd1 : elapsed_sec;
    assign total_nxt   = total_cnt + CNT_W'(key_valid && total_cnt != CNT_MAX);
    assign correct_nxt = correct_cnt + CNT_W'(key_valid && key_correct && correct_cnt != CNT_MAX);

    // Restoring divide step: remainder always stays below the divisor, so it fits in DW bits
    assign trial = {div_r, div_q[DW-1]};
    assign ge    = (trial >= {1'b0, div_d});
    assign r_nxt = ge ? DW'(trial - {1'b0, div_d}) : trial[DW-1:0];
    assign q_nxt = {div_q[DW-2:0], ge};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            total_cnt   <= '0;
            correct_cnt <= '0;
            tick_cnt    <= '0;
            elapsed_sec <= '0;
            div_q       <= '0;
            div_d       <= '0;
            div_r       <= '0;
            div_cnt     <= '0;
            wpm_tmp     <= '0;
            acc_tmp     <= '0;
            wpm         <= '0;
            acc         <= '0;
            finish      <= 1'b0;
`ifdef TYPING_STATS_ERR_OUT_EN
            err_cnt     <= '0;
`endif
        end else begin
            state  <= state_nxt;
            finish <= 1'b0;

            if (start_run) begin
                total_cnt   <= '0;
                correct_cnt <= '0;
                tick_cnt    <= '0;
                elapsed_sec <= '0;
            end else if (state == S_RUN) begin
                total_cnt   <= total_nxt;
                correct_cnt <= correct_nxt;
                tick_cnt    <= tick_nxt;
                elapsed_sec <= elapsed_nxt;
            end

            case (state)
                S_RUN: begin
                    if (stop) begin
                        div_q   <= DW'(correct_nxt) * DW'(12);
                        div_d   <= (elapsed_nxt == '0) ? DW'(1) : DW'(elapsed_nxt);
                        div_r   <= '0;
                        div_cnt <= '0;
                    end
                end
                S_DIV_W: begin
                    div_q   <= q_nxt;
                    div_r   <= r_nxt;
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == DIV_LAST) begin
                        wpm_tmp <= (q_nxt > WPM_MAX_Q) ? WPM_MAX_Q[9:0] : q_nxt[9:0];
                        div_q   <= DW'(correct_cnt) * DW'(100);
                        div_d   <= DW'(total_cnt);
                        div_r   <= '0;
                        div_cnt <= '0;
                    end
                end
                S_DIV_A: begin
                    div_q   <= q_nxt;
                    div_r   <= r_nxt;
                    div_cnt <= div_cnt + 5'd1;
                    // a zero divisor still runs all steps; its quotient is discarded
                    if (div_cnt == DIV_LAST)
                        acc_tmp <= (total_cnt == '0) ? 10'd0 : q_nxt[9:0];
                end
                S_DONE: begin
                    wpm    <= wpm_tmp;
                    acc    <= acc_tmp;
                    finish <= 1'b1;
`ifdef TYPING_STATS_ERR_OUT_EN
                    err_cnt <= total_cnt - correct_cnt;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_typing_stats.sv
// tb/tb_typing_stats.sv - scoreboard bench for typing_stats with directed rounds
module tb_typing_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start1, start2, stop, kv, kc;
    logic       busy1, busy2, fin1, fin2;
    logic [9:0] el1, el2, wpm1, wpm2, acc1, acc2;
`ifdef TYPING_STATS_ERR_OUT_EN
    logic [11:0] err1, err2;
`endif

    typing_stats #(.TICK_CYCLES(10), .CNT_W(12), .WPM_MAX(999)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop),
        .key_valid(kv), .key_correct(kc), .busy(busy1), .elapsed_sec(el1),
        .wpm(wpm1), .acc(acc1), .finish(fin1)
`ifdef TYPING_STATS_ERR_OUT_EN
        , .err_cnt(err1)
`endif
    );

    // longer second so the WPM clamp is reachable at one key per cycle
    typing_stats #(.TICK_CYCLES(1000), .CNT_W(12), .WPM_MAX(999)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop),
        .key_valid(kv), .key_correct(kc), .busy(busy2), .elapsed_sec(el2),
        .wpm(wpm2), .acc(acc2), .finish(fin2)
`ifdef TYPING_STATS_ERR_OUT_EN
        , .err_cnt(err2)
`endif
    );

    typedef struct {
        int     wpm;
        int     acc;
        int     el;
        int     err;
        longint at;
    } exp_t;

    exp_t   q1[$];
    exp_t   q2[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && fin1) begin
            if (q1.size() == 0) chk("dut1_unexpected_finish", fin1, 0);
            else begin
                e = q1.pop_front();
                chk("dut1_finish_cycle", cyc, e.at);
                chk("dut1_wpm", wpm1, e.wpm);
                chk("dut1_acc", acc1, e.acc);
                chk("dut1_elapsed_sec", el1, e.el);
`ifdef TYPING_STATS_ERR_OUT_EN
                chk("dut1_err_cnt", err1, e.err);
`endif
            end
        end
        if (rst && fin2) begin
            if (q2.size() == 0) chk("dut2_unexpected_finish", fin2, 0);
            else begin
                e = q2.pop_front();
                chk("dut2_finish_cycle", cyc, e.at);
                chk("dut2_wpm", wpm2, e.wpm);
                chk("dut2_acc", acc2, e.acc);
                chk("dut2_elapsed_sec", el2, e.el);
`ifdef TYPING_STATS_ERR_OUT_EN
                chk("dut2_err_cnt", err2, e.err);
`endif
            end
        end
    end

    // n RUN edges; keys on the first tot of them, correct on the first cor; stop on edge n
    task automatic run_round(input bit d2, input int n, input int tot, input int cor,
                             input bit ghost, input bit mid_start, input bit abort,
                             input int ew, input int ea, input int ee);
        exp_t e;
        @(negedge clk);
        kv = 1'b0; kc = 1'b0;
        if (d2) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        for (int i = 1; i <= n; i++) begin
            kv   = (i <= tot);
            kc   = (i <= cor) || (ghost && i > tot);
            stop = (i == n);
            if (i == n && !abort) begin
                e.wpm = ew; e.acc = ea; e.el = ee; e.err = tot - cor; e.at = cyc + 40;
                if (d2) q2.push_back(e); else q1.push_back(e);
            end
            @(negedge clk);
        end
        kv = 1'b0; kc = 1'b0; stop = 1'b0;
        if (mid_start) begin
            repeat (4) @(negedge clk);
            chk("busy_in_div", busy1, 1);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
        if (!abort) begin
            for (int k = 0; k < 80 && (q1.size() + q2.size()) != 0; k++) @(negedge clk);
            chk("finish_within_bound", q1.size() + q2.size(), 0);
            q1.delete();
            q2.delete();
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; stop = 1'b0; kv = 1'b0; kc = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_wpm", wpm1, 0);
        chk("reset_acc", acc1, 0);
        chk("reset_elapsed", el1, 0);
        chk("reset_busy", busy1, 0);
        chk("reset_finish", fin1, 0);
        chk("reset_dut2_wpm", wpm2, 0);
`ifdef TYPING_STATS_ERR_OUT_EN
        chk("reset_err_cnt", err1, 0);
`endif
        rst = 1'b1;

        run_round(0, 60, 60, 60, 0, 0, 0, 120, 100, 6);
        run_round(0, 100, 80, 50, 0, 0, 0, 60, 62, 10);
        run_round(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_round(0, 30, 20, 15, 1, 0, 0, 60, 75, 3);
        run_round(0, 35, 7, 5, 0, 0, 0, 20, 71, 3);

        // round restarted from RUN: earlier keys must be discarded
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; kv = 1'b1; kc = 1'b1;
        repeat (15) @(negedge clk);
        kv = 1'b0; kc = 1'b0;
        chk("wpm_hold_in_run", wpm1, 20);
        chk("busy_in_run", busy1, 1);
        run_round(0, 20, 10, 10, 0, 0, 0, 60, 100, 2);

        run_round(0, 100, 80, 50, 0, 1, 0, 60, 62, 10);
        run_round(1, 1200, 500, 500, 0, 0, 0, 999, 100, 1);

        // reset inside DIV_A aborts the round
        run_round(0, 30, 20, 15, 0, 0, 1, 0, 0, 0);
        repeat (24) @(negedge clk);
        chk("wpm_hold_in_div", wpm1, 60);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_wpm", wpm1, 0);
        chk("abort_acc", acc1, 0);
        chk("abort_elapsed", el1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_finish", fin1, 0);
`ifdef TYPING_STATS_ERR_OUT_EN
        chk("abort_err_cnt", err1, 0);
`endif
        repeat (60) @(negedge clk);
        run_round(0, 60, 60, 60, 0, 0, 0, 120, 100, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
